// File: rtl/par_to_serial_pkg.sv
// Shared types and helpers for the buffered parallel-to-serial converter.
// Holds the serializer state encoding, the FIFO word-entry type and small
// bit helpers used by the serializer.
package par_to_serial_pkg;

  // Widest data word the entry type can carry; WIDTH of the top must not exceed it.
  localparam int unsigned MaxWidth = 128;

  typedef enum logic [1:0] {
    SER_IDLE   = 2'd0,
    SER_SHIFT  = 2'd1,
    SER_PARITY = 2'd2
  } ser_state_t;

  // Word as it leaves the FIFO: bit order travels with the data.
  typedef struct packed {
    logic                msb_first;
    logic [MaxWidth-1:0] data;
  } word_entry_t;

  // Running even parity: fold one emitted bit into the accumulator.
  function automatic logic parity_step(input logic acc, input logic b);
    return acc ^ b;
  endfunction

  // Advance the entry by one bit so the next bit to emit sits at the output position
  // (bit WIDTH-1 for MSB-first, bit 0 for LSB-first).
  function automatic word_entry_t shift_entry(input word_entry_t e);
    word_entry_t r;
    r           = e;
    r.data      = e.msb_first ? (e.data << 1) : (e.data >> 1);
    return r;
  endfunction

endpackage

// File: rtl/par_word_fifo.sv
// Synchronous word FIFO with wrap-around pointers.
// Ports:
//   clk        clock, all state on posedge
//   rst        synchronous active-high reset (pointers and count to 0)
//   push       write push_data (ignored when full)
//   push_data  entry to store
//   pop        drop the head entry (ignored when empty)
//   head_data  current head entry
//   count      number of stored entries
module par_word_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [WIDTH-1:0] push_data,
  input  logic            pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CntW-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign do_push   = push && (count_q != CntW'(DEPTH));
  assign do_pop    = pop && (count_q != '0);
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/par_to_serial_fifo.sv
// Buffered parallel-to-serial converter: words enter a DEPTH-entry FIFO through a
// valid/ready handshake and leave as back-to-back serial frames, each in its own bit
// order and optionally followed by an even-parity bit.
// Ports:
//   SerClock      clock; SerReset synchronous active-high reset
//   ParValid/ParReady/BusIn/MsbFirst  parallel input handshake and word
//   SerOut/SerValidFlag/SerFirst/SerLast  registered serial output and framing
//   Level         words waiting in the FIFO (not counting the one being shifted)
module par_to_serial_fifo
  import par_to_serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 2,
  parameter bit          PARITY_EN = 1'b0
) (
  input  logic                       SerClock,
  input  logic                       SerReset,
  input  logic                       ParValid,
  output logic                       ParReady,
  input  logic [WIDTH-1:0]           BusIn,
  input  logic                       MsbFirst,
  output logic                       SerOut,
  output logic                       SerValidFlag,
  output logic                       SerFirst,
  output logic                       SerLast,
  output logic [$clog2(DEPTH+1)-1:0] Level
);

  localparam int unsigned CntW   = $clog2(WIDTH + 1);
  localparam int unsigned LevelW = $clog2(DEPTH + 1);

  ser_state_t        state_q;
  word_entry_t       sr_q;
  logic [CntW-1:0]   bit_cnt_q;  // data bits of the current frame already emitted
  logic              parity_q;

  logic [WIDTH:0]    fifo_head;
  word_entry_t       head_entry;
  logic              head_bit, cur_bit;
  logic              push, pop, pop_slot, frame_done;

  assign ParReady = !SerReset && (Level != LevelW'(DEPTH));
  assign push     = ParValid && ParReady;

  par_word_fifo #(
    .WIDTH(WIDTH + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (SerClock),
    .rst      (SerReset),
    .push     (push),
    .push_data({MsbFirst, BusIn}),
    .pop      (pop),
    .head_data(fifo_head),
    .count    (Level)
  );

  always_comb begin
    head_entry           = '0;
    head_entry.msb_first = fifo_head[WIDTH];
    head_entry.data      = MaxWidth'(fifo_head[WIDTH-1:0]);
    head_bit   = head_entry.msb_first ? head_entry.data[WIDTH-1] : head_entry.data[0];
    cur_bit    = sr_q.msb_first ? sr_q.data[WIDTH-1] : sr_q.data[0];
    frame_done = (bit_cnt_q == CntW'(WIDTH));
    // Cycles where the next edge may start a new frame without a gap.
    unique case (state_q)
      SER_IDLE:   pop_slot = 1'b1;
      SER_SHIFT:  pop_slot = frame_done && !PARITY_EN;
      SER_PARITY: pop_slot = 1'b1;
      default:    pop_slot = 1'b0;
    endcase
    pop = pop_slot && (Level != '0);
  end

  always_ff @(posedge SerClock) begin
    if (SerReset) begin
      state_q      <= SER_IDLE;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      parity_q     <= 1'b0;
      SerOut       <= 1'b0;
      SerValidFlag <= 1'b0;
      SerFirst     <= 1'b0;
      SerLast      <= 1'b0;
    end else begin
      SerOut       <= 1'b0;
      SerValidFlag <= 1'b0;
      SerFirst     <= 1'b0;
      SerLast      <= 1'b0;
      if (pop) begin
        // The popped word's first bit goes out on this same edge.
        state_q      <= SER_SHIFT;
        sr_q         <= shift_entry(head_entry);
        bit_cnt_q    <= CntW'(1);
        parity_q     <= head_bit;
        SerOut       <= head_bit;
        SerValidFlag <= 1'b1;
        SerFirst     <= 1'b1;
      end else begin
        unique case (state_q)
          SER_SHIFT: begin
            if (!frame_done) begin
              sr_q         <= shift_entry(sr_q);
              bit_cnt_q    <= bit_cnt_q + CntW'(1);
              parity_q     <= parity_step(parity_q, cur_bit);
              SerOut       <= cur_bit;
              SerValidFlag <= 1'b1;
              SerLast      <= !PARITY_EN && (bit_cnt_q == CntW'(WIDTH - 1));
            end else if (PARITY_EN) begin
              state_q      <= SER_PARITY;
              SerOut       <= parity_q;
              SerValidFlag <= 1'b1;
              SerLast      <= 1'b1;
            end else begin
              state_q <= SER_IDLE;
            end
          end
          SER_PARITY: state_q <= SER_IDLE;
          default:    state_q <= SER_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_par_to_serial_fifo.sv
// Bench for par_to_serial_fifo: one instance without parity, one with parity.
// A queue-of-bits model predicts every serial cycle; literal checks pin the model.
module tb_par_to_serial_fifo;

  localparam int Width = 32;
  localparam int Depth = 2;
  localparam int Buf   = 1024;
  localparam int LogN  = 512;

  typedef struct packed {
    logic v;
    logic b;
    logic f;
    logic l;
  } sbit_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pv   [2];
  logic [31:0] bus  [2];
  logic        msb  [2];
  logic        drdy [2];
  logic        dout [2];
  logic        dval [2];
  logic        dfst [2];
  logic        dlst [2];
  logic [1:0]  dlev [2];

  int tests = 0;
  int fails = 0;

  // Model: pending serial bits per instance, in emission order.
  sbit_t mbuf [2][Buf];
  int    rd   [2];
  int    wr   [2];
  int    mlev [2];
  int    macc [2];
  sbit_t cur  [2];
  sbit_t lg    [2][LogN];
  int    lglev [2][LogN];
  int    lgn   [2];

  always #5 clk = ~clk;

  par_to_serial_fifo #(.WIDTH(32), .DEPTH(2), .PARITY_EN(1'b0)) dut0 (
    .SerClock(clk), .SerReset(rst), .ParValid(pv[0]), .ParReady(drdy[0]), .BusIn(bus[0]),
    .MsbFirst(msb[0]), .SerOut(dout[0]), .SerValidFlag(dval[0]), .SerFirst(dfst[0]),
    .SerLast(dlst[0]), .Level(dlev[0])
  );

  par_to_serial_fifo #(.WIDTH(32), .DEPTH(2), .PARITY_EN(1'b1)) dut1 (
    .SerClock(clk), .SerReset(rst), .ParValid(pv[1]), .ParReady(drdy[1]), .BusIn(bus[1]),
    .MsbFirst(msb[1]), .SerOut(dout[1]), .SerValidFlag(dval[1]), .SerFirst(dfst[1]),
    .SerLast(dlst[1]), .Level(dlev[1])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic put_bit(input int d, input logic b, input logic f, input logic l);
    sbit_t e;
    e.v = 1'b1;
    e.b = b;
    e.f = f;
    e.l = l;
    mbuf[d][wr[d]] = e;
    wr[d] = (wr[d] + 1) % Buf;
  endtask

  task automatic model_step(input int d);
    logic rdy;
    int   idx;
    rdy = !rst && (mlev[d] != Depth);
    if (rst) begin
      rd[d]   = 0;
      wr[d]   = 0;
      mlev[d] = 0;
      cur[d]  = '0;
    end else begin
      if (rd[d] != wr[d]) begin
        cur[d] = mbuf[d][rd[d]];
        rd[d]  = (rd[d] + 1) % Buf;
        if (cur[d].f) mlev[d]--;
      end else begin
        cur[d] = '0;
      end
      if (pv[d] && rdy) begin
        for (int k = 0; k < Width; k++) begin
          idx = msb[d] ? (Width - 1 - k) : k;
          put_bit(d, bus[d][idx], k == 0, (k == Width - 1) && (d == 0));
        end
        if (d == 1) put_bit(d, ^bus[d], 1'b0, 1'b1);
        mlev[d]++;
        macc[d]++;
      end
    end
    if (lgn[d] < LogN) begin
      lg[d][lgn[d]]    = cur[d];
      lglev[d][lgn[d]] = mlev[d];
      lgn[d]++;
    end
  endtask

  task automatic compare(input int d);
    check($sformatf("d%0d SerValidFlag", d), 32'(dval[d]), 32'(cur[d].v));
    check($sformatf("d%0d SerOut", d), 32'(dout[d]), 32'(cur[d].b));
    check($sformatf("d%0d SerFirst", d), 32'(dfst[d]), 32'(cur[d].f));
    check($sformatf("d%0d SerLast", d), 32'(dlst[d]), 32'(cur[d].l));
    check($sformatf("d%0d Level", d), 32'(dlev[d]), 32'(mlev[d]));
    check($sformatf("d%0d ParReady", d), 32'(drdy[d]), 32'(!rst && (mlev[d] != Depth)));
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    #2;
    compare(0);
    compare(1);
  end

  task automatic clear_log(input int d);
    lgn[d]  = 0;
    macc[d] = 0;
  endtask

  function automatic int count_valid(input int d, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (lg[d][i].v) n++;
    return n;
  endfunction

  logic [31:0] w3 [3];
  logic [4:0]  exp5;
  logic        rdy_s;
  int          n_sent, guard, maxlev;

  initial begin
    for (int d = 0; d < 2; d++) begin
      pv[d] = 1'b0; bus[d] = '0; msb[d] = 1'b0;
      rd[d] = 0; wr[d] = 0; mlev[d] = 0; macc[d] = 0; lgn[d] = 0; cur[d] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset SerValidFlag", 32'(dval[0]), 0);
    check("reset Level", 32'(dlev[0]), 0);
    check("ParReady in reset", 32'(drdy[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    check("ParReady after release", 32'(drdy[0]), 1);

    // 1: single MSB-first word
    clear_log(0);
    bus[0] = 32'h1111_6666; msb[0] = 1'b1; pv[0] = 1'b1;
    @(negedge clk);
    pv[0] = 1'b0;
    repeat (40) @(negedge clk);
    check("t1 valid count", 32'(count_valid(0, 0, 39)), 32);
    check("t1 idle at accept", 32'(lg[0][0].v), 0);
    check("t1 SerFirst cycle 1", 32'(lg[0][1].f), 1);
    check("t1 SerLast cycle 32", 32'(lg[0][32].l), 1);
    check("t1 idle after frame", 32'(lg[0][33].v), 0);
    exp5 = 5'b0001_0;
    for (int k = 0; k < 4; k++) check($sformatf("t1 bit %0d", k + 1), 32'(lg[0][1+k].b), 32'(exp5[4-k]));

    // 2: same word LSB-first
    clear_log(0);
    bus[0] = 32'h1111_6666; msb[0] = 1'b0; pv[0] = 1'b1;
    @(negedge clk);
    pv[0] = 1'b0;
    repeat (40) @(negedge clk);
    exp5 = 5'b0110_0;
    for (int k = 0; k < 4; k++) check($sformatf("t2 bit %0d", k + 1), 32'(lg[0][1+k].b), 32'(exp5[4-k]));
    exp5 = 5'b1000_0;
    for (int k = 0; k < 4; k++) check($sformatf("t2 bit %0d", k + 29), 32'(lg[0][29+k].b), 32'(exp5[4-k]));

    // 3: three back-to-back words, ParValid held high
    w3[0] = 32'hA5A5_A5A5; w3[1] = 32'h0000_0001; w3[2] = 32'hFFFF_FFFF;
    clear_log(0);
    n_sent = 0; guard = 0;
    msb[0] = 1'b1; pv[0] = 1'b1; bus[0] = w3[0];
    while (n_sent < 3 && guard < 200) begin
      rdy_s = drdy[0];
      @(negedge clk);
      guard++;
      if (rdy_s) begin
        n_sent++;
        if (n_sent < 3) bus[0] = w3[n_sent];
      end
    end
    pv[0] = 1'b0;
    check("t3 words accepted", 32'(n_sent), 3);
    repeat (110) @(negedge clk);
    check("t3 contiguous valid", 32'(count_valid(0, 1, 96)), 96);
    check("t3 idle after 96", 32'(lg[0][97].v), 0);
    check("t3 SerFirst 1", 32'(lg[0][1].f), 1);
    check("t3 SerFirst 33", 32'(lg[0][33].f), 1);
    check("t3 SerFirst 65", 32'(lg[0][65].f), 1);
    check("t3 bit 1", 32'(lg[0][1].b), 1);
    check("t3 bit 2", 32'(lg[0][2].b), 0);
    check("t3 bit 63", 32'(lg[0][63].b), 0);
    check("t3 bit 64", 32'(lg[0][64].b), 1);
    check("t3 bit 96", 32'(lg[0][96].b), 1);
    maxlev = 0;
    for (int i = 0; i < 100; i++) if (lglev[0][i] > maxlev) maxlev = lglev[0][i];
    check("t3 fifo reached full", 32'(maxlev), 2);

    // 4: parity instance, 7 then 3
    clear_log(1);
    bus[1] = 32'h0000_0007; msb[1] = 1'b0; pv[1] = 1'b1;
    @(negedge clk);
    bus[1] = 32'h0000_0003;
    @(negedge clk);
    pv[1] = 1'b0;
    repeat (75) @(negedge clk);
    check("t4 words accepted", 32'(macc[1]), 2);
    check("t4 valid count", 32'(count_valid(1, 0, 76)), 66);
    check("t4 no SerLast on bit 32", 32'(lg[1][32].l), 0);
    check("t4 SerLast bit 33", 32'(lg[1][33].l), 1);
    check("t4 parity 1", 32'(lg[1][33].b), 1);
    check("t4 second SerFirst", 32'(lg[1][34].f), 1);
    check("t4 second SerLast", 32'(lg[1][66].l), 1);
    check("t4 parity 2", 32'(lg[1][66].b), 0);
    check("t4 idle after", 32'(lg[1][67].v), 0);

    // 5: reset after 10 bits with one word queued
    clear_log(0);
    bus[0] = 32'hDEAD_BEEF; msb[0] = 1'b1; pv[0] = 1'b1;
    @(negedge clk);
    bus[0] = 32'h1234_5678;
    @(negedge clk);
    pv[0] = 1'b0;
    repeat (9) @(negedge clk);
    check("t5 bit 10 valid", 32'(lg[0][10].v), 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5 SerValidFlag after reset", 32'(dval[0]), 0);
    check("t5 Level after reset", 32'(dlev[0]), 0);
    check("t5 model idle after reset", 32'(lg[0][11].v), 0);
    rst = 1'b0;
    @(negedge clk);
    check("t5 ParReady after release", 32'(drdy[0]), 1);
    clear_log(0);
    bus[0] = 32'hF000_000F; msb[0] = 1'b1; pv[0] = 1'b1;
    @(negedge clk);
    pv[0] = 1'b0;
    repeat (40) @(negedge clk);
    check("t5 restart SerFirst", 32'(lg[0][1].f), 1);
    check("t5 restart valid count", 32'(count_valid(0, 0, 39)), 32);
    exp5 = 5'b11110;
    for (int k = 0; k < 5; k++) check($sformatf("t5 bit %0d", k + 1), 32'(lg[0][1+k].b), 32'(exp5[4-k]));
    check("t5 last bit", 32'(lg[0][32].b), 1);

    // 6: ParValid held, BusIn changes every cycle, FIFO saturates
    clear_log(0);
    for (int i = 0; i < 80; i++) begin
      bus[0] = 32'hC000_0000 + 32'(i) * 32'h0001_0003;
      msb[0] = i[0];
      pv[0]  = 1'b1;
      @(negedge clk);
    end
    pv[0] = 1'b0;
    check("t6 words accepted", 32'(macc[0]), 5);
    repeat (140) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/par_to_serial_fifo.md
# par_to_serial_fifo

Buffered, parametrised parallel-to-serial converter, the successor to the single-word serializer. It accepts parallel words through a valid/ready handshake into a DEPTH-entry word FIFO. It emits each word as a contiguous serial frame with per-word bit order and an optional even-parity bit, and consecutive frames follow each other with no idle cycles. It sits between a parallel producer and a one-bit serial link on the SerClock domain.

## Interface
- WIDTH, 32: data bits per word (≥2).
- DEPTH, 2: FIFO word entries (≥1).
- PARITY_EN, 0: 1 appends an even-parity bit to every frame.
- SerClock  in  1  sole clock; all state changes on posedge.
- SerReset  in  1  synchronous, active-high reset.
- ParValid  in  1  producer has a word on BusIn.
- ParReady  out  1  FIFO can accept a word.
- BusIn  in  WIDTH  parallel word.
- MsbFirst  in  1  bit order for the word; sampled with BusIn on acceptance.
- SerOut  out  1  serial data bit.
- SerValidFlag  out  1  SerOut carries a frame bit this cycle.
- SerFirst  out  1  first bit of the frame.
- SerLast  out  1  last bit of the frame (the parity bit when PARITY_EN=1).
- Level  out  $clog2(DEPTH+1)  number of words held in the FIFO, excluding the word being shifted.

## Operation
- Accept: a word is accepted on a posedge where ParValid && ParReady. {MsbFirst, BusIn} is written to the FIFO.
- ParReady = !SerReset && (Level != DEPTH). It is combinational from registers.
- A full FIFO never accepts a word, even if a pop occurs in the same cycle.
- Serializer states, defined in the package: SER_IDLE, SER_SHIFT, SER_PARITY.
- SER_IDLE: if the FIFO is non-empty, pop the head word into the shift register, clear the bit counter and go to SER_SHIFT.
- SER_SHIFT: emit one data bit per cycle.
  - Order: BusIn[WIDTH-1] down to [0] when MsbFirst=1, otherwise [0] up to [WIDTH-1].
  - Parity accumulates as the XOR of the emitted bits.
  - After bit WIDTH-1 is emitted: go to SER_PARITY if PARITY_EN=1. Otherwise, pop the next word if the FIFO is non-empty (staying in SER_SHIFT), else go to SER_IDLE.
- SER_PARITY: emit the parity bit so the frame's total count of 1s is even. Then pop the next word if available (to SER_SHIFT), else go to SER_IDLE.
- Simultaneous push and pop in one cycle: Level is unchanged, and both pointers advance.
- Outputs SerOut, SerValidFlag, SerFirst and SerLast are registered.
  - SerOut = 0 whenever SerValidFlag = 0.
  - SerFirst and SerLast are asserted only with SerValidFlag.
  - When WIDTH bits form the whole frame, SerFirst and SerLast fall on different cycles, since WIDTH ≥ 2.
- BusIn and MsbFirst are ignored whenever ParReady=0 or ParValid=0.

## Timing
- Reset values: SerOut=0, SerValidFlag=0, SerFirst=0, SerLast=0, Level=0. The state is SER_IDLE and the FIFO pointers are 0.
- ParReady is 0 while SerReset=1 and 1 in the first cycle after reset is released.
- Reset mid-frame: the frame is aborted and all FIFO contents are discarded. Outputs take their reset values at the same edge, with no partial-frame completion.
- Latency: a word accepted at edge N into an empty, idle block is popped at edge N+1. Its first bit is visible on SerOut after edge N+1 and held until edge N+2.
- Frame length is WIDTH cycles, or WIDTH+1 with parity. SerValidFlag stays high continuously across back-to-back frames.
- Sustained throughput is one word per frame length. ParReady deasserts only when Level reaches DEPTH.

## Structure
- Package par_to_serial_pkg holds:
  - ser_state_t enum (SER_IDLE, SER_SHIFT, SER_PARITY);
  - the word-entry struct type {msb_first, data};
  - a parity helper function.
- Sub-module par_word_fifo holds the synchronous FIFO: DEPTH entries of WIDTH+1 bits, push/pop, wrap-around pointers, count output.
- The top level contains the serializer FSM, the shift register and the bit counter of width $clog2(WIDTH+1).

## Test plan
1. Configuration WIDTH=32, DEPTH=2, PARITY_EN=0. Reset, then one word 32'h1111_6666 with MsbFirst=1. Required response:
   - SerValidFlag high for exactly 32 cycles starting after the second edge;
   - first bits 0,0,0,1;
   - SerFirst on cycle 1 and SerLast on cycle 32, then SerValidFlag=0.
2. Same word with MsbFirst=0: first bits 0,1,1,0 and last four bits 1,0,0,0.
3. Back-to-back words 32'hA5A5_A5A5, 32'h0000_0001, 32'hFFFF_FFFF with ParValid held high. Required response:
   - 96 contiguous SerValidFlag cycles;
   - SerFirst at cycles 1, 33 and 65;
   - ParReady low while Level=2;
   - the bit stream matches the words in order.
4. PARITY_EN=1 with 32'h0000_0007 then 32'h0000_0003:
   - first frame is 33 bits with parity bit 1 and SerLast on bit 33;
   - second frame has parity bit 0.
5. Reset asserted after 10 bits of a frame with one word queued:
   - SerValidFlag=0 and Level=0 from the next cycle, and ParReady=1 after release;
   - a new word restarts cleanly from its first bit.
6. Full FIFO with ParValid=1 and BusIn changing every cycle: no word accepted while ParReady=0, and only the words offered during ParReady=1 cycles appear on SerOut.
